// File: rtl/g2_pkg.sv
// Shared definitions for the g2 acquisition sequencer: the measurement-cycle
// state encoding, the frame header magic and the histogram bin count helper.
package g2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ACQ,
    DRAIN,
    DUMP,
    READ,
    DONE
  } g2_state_e;

  localparam logic [15:0] HDR_MAGIC = 16'hA5A5;

  // Number of histogram bins in one frame for a given bin-address MSB index
  function automatic int binCount(input int addrBit);
    return 1 << (addrBit + 1);
  endfunction

endpackage

// File: rtl/g2_stream_gate.sv
// Valid/ready gate for one detector timestamp stream. While open the stream
// passes straight through to the correlator; while closed the detector is
// always ready and its words are dropped. Accepted words are counted with a
// saturating counter that can be cleared at the start of a measurement.
module g2_stream_gate
  import g2_pkg::*;
#(
  parameter int DW = 32,
  parameter int CW = 32
) (
  input  logic          clk,
  input  logic          RST,
  input  logic          open,
  input  logic          clr,
  input  logic [DW-1:0] tDat,
  input  logic          tV,
  output logic          tR,
  output logic [DW-1:0] aDat,
  output logic          aV,
  input  logic          aR,
  output logic [CW-1:0] cnt
);

  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  // Zero-latency pass-through while open, discard-everything while closed
  always_comb begin
    aDat = tDat;
    aV   = open & tV;
    tR   = open ? aR : 1'b1;
  end

  // Count handshakes completed through the open gate, holding at all-ones
  always_ff @(posedge clk) begin
    if (RST) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (open && tV && aR && (cnt != '1)) begin
      cnt <= cnt + CNT_ONE;
    end
  end

endmodule

// File: rtl/g2_acq_ctrl.sv
// Acquisition sequencer for the g2 correlator. Opens both detector gates for
// the programmed window, waits a fixed drain time, pulses the correlator's
// dump input low for one cycle and then forwards one histogram frame to the
// host. Optional build macro G2_FRAME_HDR_EN prefixes each frame with a
// header word {HDR_MAGIC, frameIdx}.
module g2_acq_ctrl
  import g2_pkg::*;
#(
  parameter int iSIZE        = 31,
  parameter int g2MemAddrBit = 9,
  parameter int winBit       = 31,
  parameter int drainCycles  = 16
) (
  input  logic            clk,
  input  logic            RST,
  input  logic            start,
  input  logic [winBit:0] winLen,
  output logic            busy,
  output logic            done,
  input  logic [iSIZE:0]  t1,
  input  logic [iSIZE:0]  t2,
  input  logic            t1V,
  input  logic            t2V,
  output logic            t1R,
  output logic            t2R,
  output logic [iSIZE:0]  a1,
  output logic [iSIZE:0]  a2,
  output logic            a1V,
  output logic            a2V,
  input  logic            a1R,
  input  logic            a2R,
  output logic            g2Dump,
  input  logic [iSIZE:0]  g2Dat,
  input  logic            g2V,
  output logic            g2R,
  output logic [iSIZE:0]  hDat,
  output logic            hV,
  input  logic            hR,
  output logic [winBit:0] evt1Cnt,
  output logic [winBit:0] evt2Cnt
);

  localparam int BINS = binCount(g2MemAddrBit);
  localparam int BW   = g2MemAddrBit + 2;
  localparam int DW   = $clog2(drainCycles) + 1;

  localparam logic [BW-1:0]   LAST_BEAT  = BW'(BINS - 1);
  localparam logic [BW-1:0]   BEAT_ONE   = BW'(1);
  localparam logic [DW-1:0]   LAST_DRAIN = DW'(drainCycles - 1);
  localparam logic [DW-1:0]   DRAIN_ONE  = DW'(1);
  localparam logic [winBit:0] WIN_ONE    = (winBit + 1)'(1);

  g2_state_e state, nextState;

  logic [winBit:0] winLat;
  logic [winBit:0] winCnt;
  logic [DW-1:0]   drainCnt;
  logic [BW-1:0]   beatCnt;

  logic acqOpen, evtClr;
  logic acqLast, drainLast, beatAcc, readLast;
  logic hdrPhase;

`ifdef G2_FRAME_HDR_EN
  logic [15:0] frameIdx;
  logic        hdrSent;
  assign hdrPhase = (state == READ) && !hdrSent;
`else
  assign hdrPhase = 1'b0;
`endif

  assign acqOpen   = (state == ACQ);
  assign evtClr    = (state == IDLE) && start;
  assign acqLast   = (winLat == '0) || (winCnt == (winLat - WIN_ONE));
  assign drainLast = (drainCnt == LAST_DRAIN);
  assign beatAcc   = (state == READ) && !hdrPhase && g2V && hR;
  assign readLast  = beatAcc && (beatCnt == LAST_BEAT);

  g2_stream_gate #(.DW(iSIZE + 1), .CW(winBit + 1)) u_gate1 (
    .clk  (clk),
    .RST  (RST),
    .open (acqOpen),
    .clr  (evtClr),
    .tDat (t1),
    .tV   (t1V),
    .tR   (t1R),
    .aDat (a1),
    .aV   (a1V),
    .aR   (a1R),
    .cnt  (evt1Cnt)
  );

  g2_stream_gate #(.DW(iSIZE + 1), .CW(winBit + 1)) u_gate2 (
    .clk  (clk),
    .RST  (RST),
    .open (acqOpen),
    .clr  (evtClr),
    .tDat (t2),
    .tV   (t2V),
    .tR   (t2R),
    .aDat (a2),
    .aV   (a2V),
    .aR   (a2R),
    .cnt  (evt2Cnt)
  );

  // State register; reset aborts any measurement back to IDLE
  always_ff @(posedge clk) begin
    if (RST) state <= IDLE;
    else     state <= nextState;
  end

  // Measurement sequence: window, drain, dump edge, frame readout, done
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (start)     nextState = ACQ;
      ACQ:     if (acqLast)   nextState = DRAIN;
      DRAIN:   if (drainLast) nextState = DUMP;
      DUMP:                   nextState = READ;
      READ:    if (readLast)  nextState = DONE;
      DONE:                   nextState = IDLE;
      default:                nextState = IDLE;
    endcase
  end

  // Window, drain and beat counters; winLen is captured only on an accepted start
  always_ff @(posedge clk) begin
    if (RST) begin
      winLat   <= '0;
      winCnt   <= '0;
      drainCnt <= '0;
      beatCnt  <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          winLat <= winLen;
          winCnt <= '0;
        end
        ACQ:   winCnt   <= winCnt + WIN_ONE;
        DRAIN: drainCnt <= drainCnt + DRAIN_ONE;
        DUMP: begin
          drainCnt <= '0;
          beatCnt  <= '0;
        end
        READ:  if (beatAcc) beatCnt <= beatCnt + BEAT_ONE;
        default: ;
      endcase
    end
  end

`ifdef G2_FRAME_HDR_EN
  // Header handshake tracking and the frame index stamped into each header
  always_ff @(posedge clk) begin
    if (RST) begin
      hdrSent  <= 1'b0;
      frameIdx <= '0;
    end else begin
      if (state == DUMP)      hdrSent  <= 1'b0;
      if (hdrPhase && hR)     hdrSent  <= 1'b1;
      if (state == DONE)      frameIdx <= frameIdx + 16'd1;
    end
  end
`endif

  // Status, dump edge and readout forwarding decoded from the current state
  always_comb begin
    busy   = (state != IDLE);
    done   = (state == DONE);
    g2Dump = (state != DUMP);
    hDat   = g2Dat;
    hV     = 1'b0;
    g2R    = 1'b0;
    if (state == READ) begin
`ifdef G2_FRAME_HDR_EN
      if (hdrPhase) begin
        hDat = (iSIZE + 1)'({HDR_MAGIC, frameIdx});
        hV   = 1'b1;
        g2R  = 1'b0;
      end else
`endif
      begin
        hDat = g2Dat;
        hV   = g2V;
        g2R  = hR;
      end
    end
  end

endmodule

// File: tb/tb_g2_acq_ctrl.sv
// Self-checking bench for g2_acq_ctrl. A timeline model derived from the
// measurement rules predicts every output on every cycle; directed scenarios
// add hand-computed literal checks. Honours G2_FRAME_HDR_EN when defined.
module tb_g2_acq_ctrl;

  localparam int BINS  = 1024;
  localparam int DRAIN = 16;
`ifdef G2_FRAME_HDR_EN
  localparam bit HDR       = 1'b1;
  localparam int FRAME_LEN = BINS + 1;
`else
  localparam bit HDR       = 1'b0;
  localparam int FRAME_LEN = BINS;
`endif

  localparam int P_IDLE = 0, P_ACQ = 1, P_DRAIN = 2, P_DUMP = 3, P_READ = 4, P_DONE = 5;

  logic        clk = 1'b0;
  logic        RST, start;
  logic [31:0] winLen;
  logic        busy, done;
  logic [31:0] t1, t2;
  logic        t1V, t2V, t1R, t2R;
  logic [31:0] a1, a2;
  logic        a1V, a2V, a1R, a2R;
  logic        g2Dump;
  logic [31:0] g2Dat;
  logic        g2V, g2R;
  logic [31:0] hDat;
  logic        hV, hR;
  logic [31:0] evt1Cnt, evt2Cnt;

  always #5 clk = ~clk;

  g2_acq_ctrl dut (
    .clk(clk), .RST(RST), .start(start), .winLen(winLen),
    .busy(busy), .done(done),
    .t1(t1), .t2(t2), .t1V(t1V), .t2V(t2V), .t1R(t1R), .t2R(t2R),
    .a1(a1), .a2(a2), .a1V(a1V), .a2V(a2V), .a1R(a1R), .a2R(a2R),
    .g2Dump(g2Dump), .g2Dat(g2Dat), .g2V(g2V), .g2R(g2R),
    .hDat(hDat), .hV(hV), .hR(hR),
    .evt1Cnt(evt1Cnt), .evt2Cnt(evt2Cnt)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // timeline model
  bit          modelOn = 1'b0;
  bit          active = 1'b0;
  int          sAcq, effLen, doneCyc, beats;
  logic [31:0] e1 = '0, e2 = '0;
  logic [15:0] fIdx = '0;

  // measurements taken from the DUT outputs
  int          a1vHigh, dumpLow, dumpCyc, lastAcqCyc, beatsMeas, doneCnt;
  logic [31:0] firstWord;
  bit          firstSeen;

  // stimulus knobs
  bit hrToggle = 1'b0;
  bit g2vRandom = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic int phaseAt(input int c);
    if (!active)                              return P_IDLE;
    if (doneCyc >= 0 && c == doneCyc)         return P_DONE;
    if (c < sAcq + effLen)                    return P_ACQ;
    if (c < sAcq + effLen + DRAIN)            return P_DRAIN;
    if (c == sAcq + effLen + DRAIN)           return P_DUMP;
    return P_READ;
  endfunction

  // Per-cycle comparison against the timeline model, then model advance
  always @(negedge clk) begin
    int  ph;
    bit  hdrNow;
    bit  acc;
    cyc++;
    ph = phaseAt(cyc);
    hdrNow = HDR && (ph == P_READ) && (beats == 0);
    if (modelOn) begin
      checkOutput("busy",    busy,    ph != P_IDLE);
      checkOutput("done",    done,    ph == P_DONE);
      checkOutput("g2Dump",  g2Dump,  ph != P_DUMP);
      checkOutput("a1V",     a1V,     (ph == P_ACQ) && t1V);
      checkOutput("a2V",     a2V,     (ph == P_ACQ) && t2V);
      checkOutput("t1R",     t1R,     (ph == P_ACQ) ? a1R : 1'b1);
      checkOutput("t2R",     t2R,     (ph == P_ACQ) ? a2R : 1'b1);
      checkOutput("hV",      hV,      (ph == P_READ) && (hdrNow || g2V));
      checkOutput("g2R",     g2R,     (ph == P_READ) && !hdrNow && hR);
      checkOutput("evt1Cnt", evt1Cnt, e1);
      checkOutput("evt2Cnt", evt2Cnt, e2);
      if (ph == P_ACQ) begin
        checkOutput("a1Dat", a1, t1);
        checkOutput("a2Dat", a2, t2);
      end
      if (ph == P_READ && (hdrNow || g2V))
        checkOutput("hDat", hDat, hdrNow ? {16'hA5A5, fIdx} : g2Dat);

      if (a1V) begin a1vHigh++; lastAcqCyc = cyc; end
      if (!g2Dump) begin dumpLow++; dumpCyc = cyc; end
      if (done) doneCnt++;
      if (hV && hR) begin
        beatsMeas++;
        if (!firstSeen) begin firstWord = hDat; firstSeen = 1'b1; end
      end
    end

    if (RST) begin
      modelOn = 1'b1;
      active  = 1'b0;
      e1 = '0; e2 = '0; fIdx = '0;
    end else if (modelOn) begin
      case (ph)
        P_IDLE: if (start) begin
          active  = 1'b1;
          sAcq    = cyc + 1;
          effLen  = (winLen == 0) ? 1 : int'(winLen);
          doneCyc = -1;
          beats   = 0;
          e1 = '0; e2 = '0;
        end
        P_ACQ: begin
          if (t1V && a1R && e1 != 32'hFFFF_FFFF) e1++;
          if (t2V && a2R && e2 != 32'hFFFF_FFFF) e2++;
        end
        P_READ: begin
          acc = hdrNow ? hR : (g2V && hR);
          if (acc) begin
            beats++;
            if (beats == FRAME_LEN) doneCyc = cyc + 1;
          end
        end
        P_DONE: begin
          active = 1'b0;
          fIdx++;
        end
        default: ;
      endcase
    end
  end

  task automatic applyStimulus();
    @(posedge clk);
    #1;
    t1    = $urandom;
    t2    = $urandom;
    g2Dat = $urandom;
    if (hrToggle)  hR  = ~hR;
    if (g2vRandom) g2V = 1'($urandom_range(0, 1));
  endtask

  task automatic clearMeas();
    a1vHigh = 0; dumpLow = 0; dumpCyc = 0; lastAcqCyc = 0;
    beatsMeas = 0; doneCnt = 0; firstSeen = 1'b0; firstWord = '0;
  endtask

  task automatic waitIdle(input int maxCyc, input string name);
    int n = 0;
    while (busy !== 1'b0 && n < maxCyc) begin
      applyStimulus();
      n++;
    end
    checkOutput(name, busy, 1'b0);
  endtask

  task automatic pulseStart(input logic [31:0] len);
    winLen = len;
    start  = 1'b1;
    applyStimulus();
    start  = 1'b0;
  endtask

  initial begin
    RST = 1'b1; start = 1'b0; winLen = '0;
    t1 = '0; t2 = '0; t1V = 1'b0; t2V = 1'b0; a1R = 1'b1; a2R = 1'b1;
    g2Dat = '0; g2V = 1'b0; hR = 1'b1;
    clearMeas();
    repeat (3) applyStimulus();
    RST = 1'b0;

    // Test 1: idle after reset
    repeat (5) applyStimulus();
    checkOutput("idleDump", g2Dump, 1'b1);
    checkOutput("idleBusy", busy,   1'b0);
    checkOutput("idleT1R",  t1R,    1'b1);
    checkOutput("idleHV",   hV,     1'b0);

    // Test 2: 100-cycle window, both detectors streaming
    t1V = 1'b1; t2V = 1'b1; g2V = 1'b1; hR = 1'b1;
    clearMeas();
    checkOutput("t2PreBusy", busy, 1'b0);
    pulseStart(32'd100);
    checkOutput("t2BusyRise", busy, 1'b1);
    winLen = 32'd7;
    waitIdle(3000, "t2Timeout");
    checkOutput("t2Evt1", evt1Cnt, 32'd100);
    checkOutput("t2Evt2", evt2Cnt, 32'd100);
    checkOutput("t2A1VHigh", a1vHigh, 100);
    checkOutput("t2DumpLow", dumpLow, 1);
    checkOutput("t2DrainGap", dumpCyc - lastAcqCyc - 1, 16);
    checkOutput("t2Beats", beatsMeas, FRAME_LEN);
    checkOutput("t2Done", doneCnt, 1);
`ifdef G2_FRAME_HDR_EN
    checkOutput("t2Hdr", firstWord, 32'hA5A50000);
`endif

    // Test 3: zero-length window behaves as one cycle
    t2V = 1'b0;
    repeat (2) applyStimulus();
    clearMeas();
    pulseStart(32'd0);
    waitIdle(3000, "t3Timeout");
    checkOutput("t3Evt1", evt1Cnt, 32'd1);
    checkOutput("t3Evt2", evt2Cnt, 32'd0);
    checkOutput("t3A1VHigh", a1vHigh, 1);
`ifdef G2_FRAME_HDR_EN
    checkOutput("t3Hdr", firstWord, 32'hA5A50001);
`endif

    // Test 4: host stalls every other cycle during readout
    t2V = 1'b1;
    repeat (2) applyStimulus();
    clearMeas();
    hR = 1'b1;
    hrToggle = 1'b1;
    pulseStart(32'd12);
    waitIdle(5000, "t4Timeout");
    hrToggle = 1'b0; hR = 1'b1;
    checkOutput("t4Beats", beatsMeas, FRAME_LEN);
    checkOutput("t4Done", doneCnt, 1);
    checkOutput("t4Evt1", evt1Cnt, 32'd12);

    // Test 5: correlator back-pressure mid-window, start ignored during READ
    repeat (2) applyStimulus();
    clearMeas();
    g2vRandom = 1'b1;
    pulseStart(32'd50);
    repeat (20) applyStimulus();
    a1R = 1'b0;
    repeat (10) applyStimulus();
    a1R = 1'b1;
    begin
      int n = 0;
      while (hV !== 1'b1 && n < 200) begin applyStimulus(); n++; end
    end
    repeat (5) applyStimulus();
    pulseStart(32'd3);
    waitIdle(6000, "t5Timeout");
    g2vRandom = 1'b0; g2V = 1'b1;
    checkOutput("t5Evt1", evt1Cnt, 32'd40);
    checkOutput("t5Evt2", evt2Cnt, 32'd50);
    checkOutput("t5Beats", beatsMeas, FRAME_LEN);
    checkOutput("t5Done", doneCnt, 1);
    repeat (3) applyStimulus();
    checkOutput("t5StayIdle", busy, 1'b0);

    // Test 6: reset mid-readout, then a clean measurement
    clearMeas();
    pulseStart(32'd20);
    begin
      int n = 0;
      while (beatsMeas < 500 && n < 3000) begin applyStimulus(); n++; end
    end
    checkOutput("t6Reach500", beatsMeas, 500);
    RST = 1'b1;
    applyStimulus();
    RST = 1'b0;
    checkOutput("t6RstBusy", busy,   1'b0);
    checkOutput("t6RstG2R",  g2R,    1'b0);
    checkOutput("t6RstHV",   hV,     1'b0);
    checkOutput("t6RstDump", g2Dump, 1'b1);
    checkOutput("t6RstEvt1", evt1Cnt, 32'd0);
    repeat (2) applyStimulus();
    clearMeas();
    pulseStart(32'd30);
    waitIdle(3000, "t6Timeout");
    checkOutput("t6Evt1", evt1Cnt, 32'd30);
    checkOutput("t6Beats", beatsMeas, FRAME_LEN);
    checkOutput("t6Done", doneCnt, 1);
`ifdef G2_FRAME_HDR_EN
    checkOutput("t6Hdr", firstWord, 32'hA5A50000);
`endif

    repeat (3) applyStimulus();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
